// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - SRAM-like instruction bus between fetch_ctrl and memory
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with redirect and in-flight kill
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXC_VEC  = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        stall,
    fetch_ctrl_if.master bus,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] kill_pc, kill_pc_n;
    logic        kill, kill_n;
    logic        kill_exc, kill_exc_n;
    logic        if_valid_n;
    logic [31:0] if_pc_n, if_inst_n;
    logic        req;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        take_redirect;
    logic [31:0] kill_target;

    assign bus.inst_req  = req;
    assign bus.inst_addr = fetch_pc;

    always_comb begin
        redirect    = exception | br_take | eret;
        redirect_pc = exception ? EXC_VEC : (br_take ? br_target : epc);
        // A pending exception kill cannot be displaced by a later branch or eret
        take_redirect = redirect && (exception || !kill || !kill_exc);
        kill_target   = take_redirect ? redirect_pc : kill_pc;

        state_n    = state;
        fetch_pc_n = fetch_pc;
        kill_n     = kill;
        kill_exc_n = kill_exc;
        kill_pc_n  = kill_pc;
        if_valid_n = if_valid;
        if_pc_n    = if_pc;
        if_inst_n  = if_inst;
        req        = 1'b0;

        case (state)
            S_IDLE: begin
                if (redirect) fetch_pc_n = redirect_pc;
                state_n = S_REQ;
            end
            S_REQ: begin
                req = 1'b1;
                if (redirect) kill_n = 1'b1;
                if (take_redirect) begin
                    kill_pc_n  = redirect_pc;
                    kill_exc_n = exception;
                end
                if (bus.inst_addr_ok) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (redirect) kill_n = 1'b1;
                if (take_redirect) begin
                    kill_pc_n  = redirect_pc;
                    kill_exc_n = exception;
                end
                if (bus.inst_data_ok) begin
                    if (kill || redirect) begin
                        fetch_pc_n = kill_target;
                        kill_n     = 1'b0;
                        kill_exc_n = 1'b0;
                    end else begin
                        if_inst_n  = bus.inst_rdata;
                        if_pc_n    = fetch_pc;
                        if_valid_n = 1'b1;
                        fetch_pc_n = fetch_pc + 32'd4;
                    end
                    state_n = (kill || redirect) ? S_REQ : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    fetch_pc_n = redirect_pc;
                    state_n    = S_REQ;
                end else if (!stall) begin
                    if_valid_n = 1'b0;
                    state_n    = S_REQ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            kill     <= 1'b0;
            kill_exc <= 1'b0;
            kill_pc  <= 32'd0;
            if_valid <= 1'b0;
            if_pc    <= 32'd0;
            if_inst  <= 32'd0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            kill     <= kill_n;
            kill_exc <= kill_exc_n;
            kill_pc  <= kill_pc_n;
            if_valid <= if_valid_n;
            if_pc    <= if_pc_n;
            if_inst  <= if_inst_n;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed and randomized check of fetch_ctrl against a behavioural model
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
    localparam logic [31:0] K        = 32'h5a5a0000;
    localparam int P_BOOT = 0, P_ASK = 1, P_AWAIT = 2, P_HELD = 3;

    logic        clk = 1'b0;
    logic        resetn, exception, br_take, eret, stall;
    logic [31:0] br_target, epc;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;

    fetch_ctrl_if bus ();

    fetch_ctrl #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
        .clk(clk), .resetn(resetn), .exception(exception), .br_take(br_take),
        .br_target(br_target), .eret(eret), .epc(epc), .stall(stall),
        .bus(bus.master), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // stimulus intent, applied by tick()
    logic        s_rstn = 1'b0, s_exc = 1'b0, s_br = 1'b0, s_eret = 1'b0, s_stall = 1'b0;
    logic [31:0] s_bt = 32'd0, s_epc = 32'd0;
    logic        s_aok = 1'b0, s_dok = 1'b0;
    int          bus_mode = 0;  // 0 always ready, 1 random, 2 manual
    logic        bus_out = 1'b0;
    logic [31:0] bus_addr = 32'd0;

    // behavioural model: phase of the current fetch plus a pending-redirect record
    logic        m_known = 1'b0;
    int          m_phase = P_BOOT;
    logic [31:0] m_pc = RESET_PC, m_ipc = 32'd0, m_iinst = 32'd0, m_doom_pc = 32'd0;
    logic        m_valid = 1'b0, m_doomed = 1'b0, m_doom_exc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doom(input logic [31:0] tgt);
        if (!m_doomed || !m_doom_exc || s_exc) begin
            m_doom_pc  = tgt;
            m_doom_exc = s_exc;
        end
        m_doomed = 1'b1;
    endtask

    task automatic model_step(input logic aok, input logic dok, input logic [31:0] rd);
        logic        redir;
        logic [31:0] tgt;
        if (!s_rstn) begin
            m_known = 1'b1; m_phase = P_BOOT; m_pc = RESET_PC;
            m_valid = 1'b0; m_ipc = 32'd0; m_iinst = 32'd0;
            m_doomed = 1'b0; m_doom_exc = 1'b0;
            return;
        end
        if (!m_known) return;
        redir = s_exc | s_br | s_eret;
        tgt   = s_exc ? EXC_VEC : (s_br ? s_bt : s_epc);
        case (m_phase)
            P_BOOT: begin
                if (redir) m_pc = tgt;
                m_phase = P_ASK;
            end
            P_ASK: begin
                if (redir) doom(tgt);
                if (aok) m_phase = P_AWAIT;
            end
            P_AWAIT: begin
                if (redir) doom(tgt);
                if (dok) begin
                    if (m_doomed) begin
                        m_pc = m_doom_pc; m_doomed = 1'b0; m_phase = P_ASK;
                    end else begin
                        m_valid = 1'b1; m_ipc = m_pc; m_iinst = rd;
                        m_pc = m_pc + 32'd4; m_phase = P_HELD;
                    end
                end
            end
            default: begin
                if (redir) begin
                    m_valid = 1'b0; m_pc = tgt; m_phase = P_ASK;
                end else if (!s_stall) begin
                    m_valid = 1'b0; m_phase = P_ASK;
                end
            end
        endcase
    endtask

    // one cycle: compare at negedge, then drive the next inputs and advance the model
    task automatic tick();
        logic        aok, dok;
        logic [31:0] rd;
        @(negedge clk);
        if (m_known) begin
            chk("inst_req", {31'd0, bus.inst_req}, {31'd0, m_phase == P_ASK});
            if (m_phase == P_ASK) chk("inst_addr", bus.inst_addr, m_pc);
            chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
            if (m_valid) begin
                chk("if_pc", if_pc, m_ipc);
                chk("if_inst", if_inst, m_iinst);
            end
        end
        case (bus_mode)
            0: begin aok = bus.inst_req; dok = bus_out; end
            1: begin
                aok = bus.inst_req && ($urandom_range(0, 2) != 0);
                dok = bus_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 31) == 0);
            end
            default: begin aok = s_aok && bus.inst_req; dok = s_dok && bus_out; end
        endcase
        rd = (bus_mode == 1) ? $urandom : (bus_addr ^ K);
        resetn = s_rstn; exception = s_exc; br_take = s_br; br_target = s_bt;
        eret = s_eret; epc = s_epc; stall = s_stall;
        bus.inst_addr_ok = aok; bus.inst_data_ok = dok; bus.inst_rdata = rd;
        model_step(aok, dok, rd);
        if (dok) bus_out = 1'b0;
        if (bus.inst_req && aok) begin
            bus_out  = 1'b1;
            bus_addr = bus.inst_addr;
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        do begin tick(); n++; end while (!bus.inst_req && n < 50);
        chk(name, {31'd0, bus.inst_req}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin tick(); n++; end while (!if_valid && n < 50);
        chk(name, {31'd0, if_valid}, 32'd1);
    endtask

    initial begin
        resetn = 1'b0; exception = 1'b0; br_take = 1'b0; eret = 1'b0; stall = 1'b0;
        br_target = 32'd0; epc = 32'd0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'd0;

        tick(); tick();
        chk("rst_req", {31'd0, bus.inst_req}, 32'd0);
        chk("rst_addr", bus.inst_addr, RESET_PC);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);

        // always-ready bus: sequential fetch from reset vector
        s_rstn = 1'b1;
        tick();
        chk("idle_req", {31'd0, bus.inst_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, bus.inst_req}, 32'd1);
        chk("first_addr", bus.inst_addr, 32'hbfc00000);
        wait_valid("valid0");
        chk("pc0", if_pc, 32'hbfc00000);
        chk("inst0", if_inst, 32'hbfc00000 ^ K);
        wait_valid("valid1");
        chk("pc1", if_pc, 32'hbfc00004);

        // stall holds the instruction
        s_stall = 1'b1;
        wait_valid("valid2");
        chk("pc2", if_pc, 32'hbfc00008);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_pc", if_pc, 32'hbfc00008);
            chk("stall_inst", if_inst, 32'hbfc00008 ^ K);
            chk("stall_req", {31'd0, bus.inst_req}, 32'd0);
        end
        s_stall = 1'b0;
        tick();
        chk("stall_fall_req", {31'd0, bus.inst_req}, 32'd0);
        tick();
        chk("after_stall_req", {31'd0, bus.inst_req}, 32'd1);
        chk("after_stall_addr", bus.inst_addr, 32'hbfc0000c);

        // branch in WAIT, same cycle as data_ok
        s_br = 1'b1; s_bt = 32'hbfc01000;
        tick();
        s_br = 1'b0;
        tick();
        chk("br_drop_valid", {31'd0, if_valid}, 32'd0);
        chk("br_req", {31'd0, bus.inst_req}, 32'd1);
        chk("br_addr", bus.inst_addr, 32'hbfc01000);

        // exception+branch together, then branch next cycle, all in REQ
        bus_mode = 2; s_aok = 1'b0; s_dok = 1'b1;
        wait_req("exc_reach_req");
        s_exc = 1'b1; s_br = 1'b1; s_bt = 32'h12345678;
        tick();
        s_exc = 1'b0; s_bt = 32'h22222220;
        tick();
        s_br = 1'b0; s_aok = 1'b1;
        tick();
        s_aok = 1'b0;
        wait_req("exc_req");
        chk("exc_addr", bus.inst_addr, EXC_VEC);
        chk("exc_valid", {31'd0, if_valid}, 32'd0);

        // branch in WAIT without data_ok
        s_aok = 1'b1;
        tick();
        s_aok = 1'b0; s_dok = 1'b0; s_br = 1'b1; s_bt = 32'h00001000;
        tick();
        s_br = 1'b0;
        tick();
        s_dok = 1'b1;
        wait_req("brw_req");
        chk("brw_addr", bus.inst_addr, 32'h00001000);

        // eret in HOLD
        s_aok = 1'b1; s_stall = 1'b1;
        wait_valid("eret_hold");
        chk("eret_hold_pc", if_pc, 32'h00001000);
        s_eret = 1'b1; s_epc = 32'h80000010;
        tick();
        s_eret = 1'b0;
        tick();
        chk("eret_valid", {31'd0, if_valid}, 32'd0);
        chk("eret_addr", bus.inst_addr, 32'h80000010);

        // address wrap
        wait_valid("wrap_hold");
        s_br = 1'b1; s_bt = 32'hfffffffc;
        tick();
        s_br = 1'b0; s_stall = 1'b0;
        wait_valid("wrap_valid");
        chk("wrap_pc", if_pc, 32'hfffffffc);
        tick();
        chk("wrap_addr", bus.inst_addr, 32'h00000000);

        // reset during WAIT, then late data_ok
        s_dok = 1'b0; s_rstn = 1'b0;
        tick();
        s_rstn = 1'b1; s_dok = 1'b1;
        tick();
        chk("rstw_req", {31'd0, bus.inst_req}, 32'd0);
        chk("rstw_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("rstw_req2", {31'd0, bus.inst_req}, 32'd1);
        chk("rstw_addr", bus.inst_addr, RESET_PC);
        chk("rstw_valid2", {31'd0, if_valid}, 32'd0);
        wait_valid("rstw_fetch");
        chk("rstw_pc", if_pc, RESET_PC);

        // randomized traffic
        bus_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            s_rstn  = ($urandom_range(0, 299) != 0);
            s_exc   = ($urandom_range(0, 24) == 0);
            s_br    = ($urandom_range(0, 14) == 0);
            s_eret  = ($urandom_range(0, 19) == 0);
            s_bt    = $urandom;
            s_epc   = $urandom;
            s_stall = ($urandom_range(0, 2) == 0);
            tick();
        end
        s_exc = 1'b0; s_br = 1'b0; s_eret = 1'b0; s_rstn = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the SRAM-like instruction bus. It runs a one-outstanding-request handshake with the bus and holds each fetched instruction for the decode stage. It applies redirects (exception, branch, eret) with fixed priority, and discards responses to requests that were in flight when a redirect arrived.

## Interface
- RESET_PC, 32'hbfc00000, first fetch address after reset
- EXC_VEC, 32'hbfc00380, exception entry address
- clk  in  1  clock, all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- exception  in  1  single-cycle pulse; redirect to EXC_VEC
- br_take  in  1  single-cycle pulse; redirect to br_target
- br_target  in  32  branch target
- eret  in  1  single-cycle pulse; redirect to epc
- epc  in  32  eret return address
- stall  in  1  decode cannot accept the held instruction
- inst_req  out  1  bus request valid
- inst_addr  out  32  bus request address
- inst_addr_ok  in  1  bus accepted request this cycle
- inst_data_ok  in  1  bus returns read data this cycle
- inst_rdata  in  32  bus read data
- if_valid  out  1  if_pc/if_inst hold a valid instruction
- if_pc  out  32  PC of held instruction
- if_inst  out  32  held instruction word

## Operation
- Redirect event: any of exception, br_take, eret high. Target priority: exception (EXC_VEC) > br_take (br_target) > eret (epc).
- Registers: state, fetch_pc, kill, kill_pc, if_pc, if_inst, if_valid.
- S_IDLE: entered on reset. inst_req=0. Next cycle goes to S_REQ. A redirect in this cycle loads fetch_pc with the target.
- S_REQ: inst_req=1, inst_addr=fetch_pc. Address stays stable until inst_addr_ok. On inst_addr_ok, go to S_WAIT.
  - A redirect in S_REQ sets kill=1 and kill_pc=target. The handshake completes normally.
- S_WAIT: inst_req=0. Waits for inst_data_ok.
  - Redirect in S_WAIT sets kill/kill_pc, including in the same cycle as data_ok.
  - On data_ok with kill set or a redirect this cycle: discard data, fetch_pc<=target, kill<=0, go to S_REQ.
  - On data_ok otherwise: if_inst<=inst_rdata, if_pc<=fetch_pc, if_valid<=1, fetch_pc<=fetch_pc+4, go to S_HOLD.
- kill overwrite rule:
  - A redirect carrying exception always overwrites kill_pc.
  - br_take/eret overwrite kill_pc only if the pending kill was not caused by an exception. Track this with a kill_exc bit.
- S_HOLD: if_valid=1.
  - On a redirect: if_valid<=0, fetch_pc<=target, go to S_REQ.
  - Else if stall=0: if_valid<=0, go to S_REQ. The instruction is consumed in this cycle.
  - Else stay; if_pc/if_inst are stable.
- Arithmetic: fetch_pc+4 wraps mod 2^32. No alignment check is done here; address errors are flagged downstream.
- inst_data_ok outside S_WAIT is a bus protocol violation and is ignored.

## Timing
- Reset values: state=S_IDLE, fetch_pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, kill=0.
- Reset asserted in any state returns to S_IDLE next edge and drops inst_req. An outstanding bus response arriving after reset is ignored because the block is not in S_WAIT.
- First inst_req is asserted on the second cycle after resetn rises.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT with data_ok, HOLD).
- if_valid rises the cycle after data_ok.
- A redirect in S_HOLD produces inst_addr=target in the next cycle.

## Test plan
- Reset release, bus always ready (addr_ok in S_REQ, data_ok one cycle later) -> first request at 0xbfc00000; if_pc sequence 0xbfc00000, 0xbfc00004, 0xbfc00008; if_inst equals returned data.
- stall=1 for 4 cycles in S_HOLD -> if_valid, if_pc, if_inst unchanged; no inst_req until the cycle after stall falls.
- br_take with br_target=0xbfc01000 during S_WAIT -> returned word dropped (if_valid stays 0); next inst_addr=0xbfc01000.
- exception and br_take in the same cycle, and exception then br_take in successive cycles during S_REQ -> next useful fetch at 0xbfc00380.
- eret with epc=0x80000010 in S_HOLD -> if_valid falls; next cycle inst_addr=0x80000010.
- fetch_pc=0xfffffffc fetched -> next inst_addr=0x00000000; resetn low while in S_WAIT -> S_IDLE, inst_req=0, and a late data_ok produces no if_valid.
